// File: rtl/qtcore_bridge_pkg.sv
// ============================================================================
// qtcore_bridge_pkg : shared types for the qtcore scan bridge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package qtcore_bridge_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SCAN = 2'b01,
    OP_STAT = 2'b10,
    OP_RUN  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SCAN = 3'd2,
    ST_STAT = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qtcore_scan_bridge_if.sv
// ============================================================================
// qtcore_scan_bridge_if : serial host link plus per-core scan/halt/enable bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface qtcore_scan_bridge_if #(
  parameter int NCH = 4
);
  logic           cs_n;
  logic           sdi;
  logic           sdo;
  logic [NCH-1:0] ch_scan_en;
  logic [NCH-1:0] ch_scan_in;
  logic [NCH-1:0] ch_scan_out;
  logic [NCH-1:0] halt_in;
  logic [NCH-1:0] proc_en;
  logic           frame_done;

  modport master (
    output cs_n, sdi, ch_scan_out, halt_in,
    input  sdo, ch_scan_en, ch_scan_in, proc_en, frame_done
  );

  modport slave (
    input  cs_n, sdi, ch_scan_out, halt_in,
    output sdo, ch_scan_en, ch_scan_in, proc_en, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/qtcore_sync2.sv
// ============================================================================
// qtcore_sync2 : two-flop synchroniser, async active-low reset, settable reset
// value. Only compiled when BRIDGE_SYNC_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifdef BRIDGE_SYNC_EN
module qtcore_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {2{RST_VAL}};
    else        r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];
endmodule
`endif

`default_nettype wire

// File: rtl/qtcore_scan_bridge.sv
// ============================================================================
// qtcore_scan_bridge : SPI-style frame decoder driving per-core scan chains,
// halt status readback and processor enables. Optional macro BRIDGE_SYNC_EN
// adds two-flop synchronisers on cs_n and sdi.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module qtcore_scan_bridge
  import qtcore_bridge_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CHAIN_LEN = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  qtcore_scan_bridge_if.slave bus
);
  localparam int CHW     = $clog2(NCH);
  localparam int HDR_LEN = 2 + CHW;
  localparam int CNTW    = $clog2(max2(CHAIN_LEN, NCH) + 1);

  localparam logic [CNTW-1:0] c_hdr_last  = CNTW'(HDR_LEN - 2);
  localparam logic [CNTW-1:0] c_scan_last = CNTW'(CHAIN_LEN - 1);
  localparam logic [CNTW-1:0] c_stat_last = CNTW'(NCH - 1);

  logic w_cs_n;
  logic w_sdi;

`ifdef BRIDGE_SYNC_EN
  qtcore_sync2 #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .rst_n(rst_n), .i_d(bus.cs_n), .o_q(w_cs_n));
  qtcore_sync2 #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .rst_n(rst_n), .i_d(bus.sdi),  .o_q(w_sdi));
`else
  assign w_cs_n = bus.cs_n;
  assign w_sdi  = bus.sdi;
`endif

  state_e              r_state;
  state_e              w_next;
  logic [CNTW-1:0]     r_cnt;
  logic [HDR_LEN-2:0]  r_hdr;
  logic [HDR_LEN-1:0]  w_hdr;
  logic [CHW-1:0]      r_ch;
  logic [CHW-1:0]      w_hdr_ch;
  op_e                 w_hdr_op;
  logic [NCH-1:0]      r_sr;
  logic [NCH-1:0]      r_proc_en;
  logic [NCH-1:0]      w_sel;
  logic                r_frame_done;
  logic                w_done;
  logic                w_decode;
  logic                w_ch_ok;
  logic                w_scan_act;

  // Full header as seen on the edge that samples its last bit
  assign w_hdr    = {r_hdr, w_sdi};
  assign w_hdr_op = op_e'(w_hdr[HDR_LEN-1 -: 2]);
  assign w_hdr_ch = w_hdr[CHW-1:0];
  assign w_ch_ok  = (32'(w_hdr_ch) < NCH);
  assign w_sel    = NCH'(1) << r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_decode = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_cs_n) w_next = ST_HDR;
      ST_HDR: begin
        if (w_cs_n) begin
          w_next = ST_IDLE;
        end else if (r_cnt == c_hdr_last) begin
          w_decode = 1'b1;
          if (!w_ch_ok) begin
            w_next = ST_DONE;
            w_done = 1'b1;
          end else begin
            case (w_hdr_op)
              OP_NOP:  begin w_next = ST_DONE; w_done = 1'b1; end
              OP_SCAN: w_next = ST_SCAN;
              OP_STAT: w_next = ST_STAT;
              default: w_next = ST_RUN;
            endcase
          end
        end
      end
      ST_SCAN: begin
        if (w_cs_n)                    w_next = ST_IDLE;
        else if (r_cnt == c_scan_last) begin w_next = ST_DONE; w_done = 1'b1; end
      end
      ST_STAT: begin
        if (w_cs_n)                    w_next = ST_IDLE;
        else if (r_cnt == c_stat_last) begin w_next = ST_DONE; w_done = 1'b1; end
      end
      ST_RUN: begin
        if (w_cs_n) w_next = ST_IDLE;
        else        begin w_next = ST_DONE; w_done = 1'b1; end
      end
      ST_DONE: if (w_cs_n) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_hdr        <= '0;
      r_ch         <= '0;
      r_sr         <= '0;
      r_proc_en    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state inside {ST_HDR, ST_SCAN, ST_STAT})
        r_cnt <= r_cnt + 1'b1;
      if (!w_cs_n && (r_state == ST_IDLE || r_state == ST_HDR))
        r_hdr <= {r_hdr[HDR_LEN-3:0], w_sdi};
      if (w_decode)
        r_ch <= w_hdr_ch;
      if (w_decode && w_ch_ok && w_hdr_op == OP_STAT)
        r_sr <= bus.halt_in;
      else if (r_state == ST_STAT && !w_cs_n)
        r_sr <= r_sr << 1;
      if (r_state == ST_RUN && !w_cs_n)
        r_proc_en[r_ch] <= w_sdi;
    end
  end

  // Scan strobes are gated by cs_n so a dropped frame stops shifting at once
  assign w_scan_act     = (r_state == ST_SCAN) && !w_cs_n;
  assign bus.ch_scan_en = w_scan_act ? w_sel : '0;
  assign bus.ch_scan_in = (w_scan_act && w_sdi) ? w_sel : '0;
  assign bus.sdo        = (r_state == ST_SCAN) ? bus.ch_scan_out[r_ch] :
                          (r_state == ST_STAT) ? r_sr[NCH-1] : 1'b0;
  assign bus.proc_en    = r_proc_en;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: doc/qtcore_scan_bridge.md
QTCORE_SCAN_BRIDGE -- requirements
Module: qtcore_scan_bridge

Interface
REQ-001 Parameter NCH, default 4, number of scan channels (cores); legal 2..8.
REQ-002 Parameter CHAIN_LEN, default 16, bits per channel scan chain; legal 2..1024.
REQ-003 Localparams: CHW = clog2(NCH); HDR_LEN = 2+CHW; CNTW = clog2(max(CHAIN_LEN,NCH)+1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cs_n  input  1  frame select, active-low (SPI style).
REQ-007 sdi  input  1  serial data in, MSB first.
REQ-008 sdo  output  1  serial data out (miso).
REQ-009 ch_scan_en  output  NCH  per-channel scan enable, one-hot or zero.
REQ-010 ch_scan_in  output  NCH  per-channel scan data in.
REQ-011 ch_scan_out  input  NCH  per-channel scan data out.
REQ-012 halt_in  input  NCH  per-channel halt flags.
REQ-013 proc_en  output  NCH  per-channel processor enable, registered.
REQ-014 frame_done  output  1  one-cycle pulse when a command completes.

Function
REQ-015 Frame = HDR_LEN header bits {op[1:0], ch[CHW-1:0]} MSB first, then payload; one bit sampled per clk while cs_n low.
REQ-016 States: IDLE, HDR, SCAN, STAT, RUN, DONE.
REQ-017 IDLE: cs_n low -> sample header bit 0, go HDR; else stay.
REQ-018 HDR: after header bit HDR_LEN-1 sampled, decode: op 00 NOP -> DONE (frame_done pulses); 01 SCAN; 10 STAT (capture halt_in into shift register same edge); 11 RUN; ch >= NCH -> DONE, no effect, frame_done still pulses.
REQ-019 SCAN: ch_scan_en[ch]=1 combinationally while state SCAN and cs_n low; ch_scan_in[ch]=sdi; sdo=ch_scan_out[ch]; exactly CHAIN_LEN cycles, then DONE with frame_done pulse.
REQ-020 STAT: sdo = shift register MSB (halt_in[NCH-1] first); shift each cycle; NCH cycles, then DONE.
REQ-021 RUN: next sdi bit loaded into proc_en[ch]; other bits unchanged; then DONE.
REQ-022 DONE: ignore sdi, sdo=0; cs_n high -> IDLE.
REQ-023 sdo=0 in IDLE, HDR, RUN, DONE.
REQ-024 Unselected ch_scan_en and ch_scan_in bits SHALL be 0 at all times.
REQ-025 cs_n high in any state -> IDLE next edge, no frame_done; bits already shifted into a chain stay shifted; proc_en unchanged.
REQ-026 Bit counter saturates never: compare-equal terminate, reload 0 on every state entry.

Reset
REQ-027 rst_n low: state IDLE, counter 0, shift register 0, proc_en all 0, frame_done 0; all outputs 0 while held.
REQ-028 Reset mid-frame SHALL abort identically to REQ-027; first frame after release starts at header bit 0.

Configuration
REQ-029 Macro BRIDGE_SYNC_EN defined: cs_n and sdi pass through two-flop synchronisers (reset to cs_n=1, sdi=0); all sampling referenced to synchronised copies, adding exactly 2 cycles latency; ch_scan_in driven from synchronised sdi.
REQ-030 Macro undefined: cs_n and sdi used directly, zero added latency, no synchroniser flops.

Structure
REQ-031 Package qtcore_bridge_pkg: op enum (OP_NOP, OP_SCAN, OP_STAT, OP_RUN) and state enum.
REQ-032 One sub-module qtcore_sync2 (2-flop synchroniser, async active-low reset, parametrised reset value), instantiated only under BRIDGE_SYNC_EN.

Verification (NCH=4, CHAIN_LEN=16, macro undefined)
REQ-033 Header 01_10 then 16 sdi bits 0xA5C3 -> ch_scan_en=4'b0100 for exactly 16 cycles, chain 2 receives 0xA5C3, sdo returns prior chain contents, frame_done one pulse.
REQ-034 halt_in=4'b1001, header 10_00 -> sdo emits 1,0,0,1 over 4 cycles, then 0.
REQ-035 Header 11_11, payload 1 -> proc_en=4'b1000; then header 11_11 payload 0 -> proc_en=4'b0000.
REQ-036 SCAN frame, cs_n raised after 5 payload bits -> ch_scan_en=0 next cycle, no frame_done, state IDLE; next full frame correct.
REQ-037 rst_n low during SCAN at bit 8 -> all outputs 0 immediately, proc_en cleared.
REQ-038 Repeat REQ-033 with BRIDGE_SYNC_EN -> same data, every response delayed exactly 2 cycles.
